// File: rtl/sudoku_pkg.sv
// sudoku_pkg: board geometry, controller states and cell/group helpers for the sudoku game.
package sudoku_pkg;
  localparam int CELL_W = 5;
  localparam int N_CELLS = 81;
  localparam int BOARD_W = 405;
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, CHECK, SOLVED} state_t;
  // Groups 0-8 are rows, 9-17 columns, 18-26 boxes in row-major box order.
  function automatic logic [6:0] group_cell(input logic [4:0] g, input logic [3:0] k);
    int gi, ki, r, c;
    gi = int'(g);
    ki = int'(k);
    if (gi < 9) begin
      r = gi;
      c = ki;
    end else if (gi < 18) begin
      r = ki;
      c = gi - 9;
    end else begin
      r = (gi - 18) / 3 * 3 + ki / 3;
      c = (gi - 18) % 3 * 3 + ki % 3;
    end
    return 7'(r * 9 + c);
  endfunction
  function automatic logic [3:0] cell_digit(input logic [BOARD_W-1:0] b, input logic [6:0] i);
    return b[int'(i) * CELL_W +: 4];
  endfunction
  function automatic logic cell_locked(input logic [BOARD_W-1:0] b, input logic [6:0] i);
    return b[int'(i) * CELL_W + 4];
  endfunction
  function automatic logic [4:0] load_cell(input logic [3:0] d);
    return (d != 4'd0 && d <= 4'd9) ? {1'b1, d} : 5'd0;
  endfunction
endpackage

// File: rtl/sudoku_game_ctrl_if.sv
// sudoku_game_ctrl_if: player buttons, puzzle input and board/status outputs of the game controller.
interface sudoku_game_ctrl_if;
  import sudoku_pkg::*;
  logic up_button, down_button, left_button, right_button;
  logic start_button, a_button, b_button;
  logic [BOARD_W-1:0] initial_board, board;
  logic [3:0] cursor_row, cursor_col;
  logic busy, solved, check_fail;
  modport master (
    output up_button, down_button, left_button, right_button, start_button, a_button, b_button,
    output initial_board,
    input board, cursor_row, cursor_col, busy, solved, check_fail
  );
  modport slave (
    input up_button, down_button, left_button, right_button, start_button, a_button, b_button,
    input initial_board,
    output board, cursor_row, cursor_col, busy, solved, check_fail
  );
endinterface

// File: rtl/sudoku_game_ctrl_button_edge.sv
// button_edge: rising-edge detector; the previous level resets high so a held button never fires.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);
  logic prev_q, prev_d;
  assign prev_d = level;
  assign pulse = level & ~prev_q;
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else prev_q <= prev_d;
  end
endmodule

// File: rtl/sudoku_game_ctrl.sv
// sudoku_game_ctrl: button-driven board editing, puzzle load and sequential 243-cell rule check.
module sudoku_game_ctrl
  import sudoku_pkg::*;
(
  input logic clk,
  input logic reset,
  sudoku_game_ctrl_if.slave bus
);
  logic [6:0] lvl, edg;
  state_t state_q, state_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [3:0] row_q, row_d, col_q, col_d, k_q, k_d;
  logic [4:0] g_q, g_d;
  logic [8:0] seen_q, seen_d, hit;
  logic fail_q, fail_d;
  logic [6:0] cur, scan;
  logic [3:0] cur_dig, scan_dig;
  // Bit order is the action priority: start, up, down, left, right, a, b.
  assign lvl = {bus.b_button, bus.a_button, bus.right_button, bus.left_button,
                bus.down_button, bus.up_button, bus.start_button};
  for (genvar i = 0; i < 7; i++) begin : g_edge
    button_edge u_edge (.clk(clk), .reset(reset), .level(lvl[i]), .pulse(edg[i]));
  end
  assign cur = 7'(row_q * 9 + col_q);
  assign cur_dig = cell_digit(board_q, cur);
  assign scan = group_cell(g_q, k_q);
  assign scan_dig = cell_digit(board_q, scan);
  assign hit = scan_dig == 4'd0 ? 9'd0 : 9'd1 << (scan_dig - 4'd1);
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    row_d = row_q;
    col_d = col_q;
    g_d = g_q;
    k_d = k_q;
    seen_d = seen_q;
    fail_d = 1'b0;
    case (state_q)
      IDLE: state_d = edg[0] ? LOAD : IDLE;
      LOAD: begin
        for (int i = 0; i < N_CELLS; i++)
          board_d[i * CELL_W +: CELL_W] = load_cell(bus.initial_board[i * CELL_W +: 4]);
        row_d = 4'd0;
        col_d = 4'd0;
        state_d = PLAY;
      end
      PLAY: begin
        if (edg[0]) begin
          state_d = CHECK;
          g_d = 5'd0;
          k_d = 4'd0;
          seen_d = 9'd0;
        end else if (edg[1]) row_d = row_q == 4'd0 ? 4'd8 : row_q - 4'd1;
        else if (edg[2]) row_d = row_q == 4'd8 ? 4'd0 : row_q + 4'd1;
        else if (edg[3]) col_d = col_q == 4'd0 ? 4'd8 : col_q - 4'd1;
        else if (edg[4]) col_d = col_q == 4'd8 ? 4'd0 : col_q + 4'd1;
        else if ((edg[5] || edg[6]) && !cell_locked(board_q, cur))
          board_d[int'(cur) * CELL_W +: 4] = edg[5] ? (cur_dig >= 4'd9 ? 4'd1 : cur_dig + 4'd1) : 4'd0;
      end
      CHECK: begin
        if (scan_dig == 4'd0 || (seen_q & hit) != 9'd0) begin
          fail_d = 1'b1;
          state_d = PLAY;
        end else if (k_q == 4'd8) begin
          k_d = 4'd0;
          seen_d = 9'd0;
          g_d = g_q + 5'd1;
          state_d = g_q == 5'd26 ? SOLVED : CHECK;
        end else begin
          k_d = k_q + 4'd1;
          seen_d = seen_q | hit;
        end
      end
      SOLVED: state_d = edg[0] ? IDLE : SOLVED;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      board_q <= '0;
      row_q <= 4'd0;
      col_q <= 4'd0;
      g_q <= 5'd0;
      k_q <= 4'd0;
      seen_q <= 9'd0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      row_q <= row_d;
      col_q <= col_d;
      g_q <= g_d;
      k_q <= k_d;
      seen_q <= seen_d;
      fail_q <= fail_d;
    end
  end
  assign bus.board = board_q;
  assign bus.cursor_row = row_q;
  assign bus.cursor_col = col_q;
  assign bus.busy = state_q == LOAD || state_q == CHECK;
  assign bus.solved = state_q == SOLVED;
  assign bus.check_fail = fail_q;
endmodule
